// File: rtl/normalizer_pkg.sv
// Shared widths and state encoding for the iterative leading/trailing-zero normalizer.
package normalizer_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned COUNT_W    = 5;
  localparam int unsigned ZERO_COUNT = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/normalizer_shift_step.sv
// One normalization step: single-bit shift toward the target end plus target/zero tests.
module shift_step
  import normalizer_pkg::*;
(
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_shifted_c,
  output logic             o_target_c,
  output logic             o_zero_c
);

  // i_dir=0 walks toward bit 15, i_dir=1 walks toward bit 0; vacated bit is zero-filled
  always_comb begin
    o_shifted_c = '0;
    o_target_c  = 1'b0;
    if (i_dir) begin
      o_shifted_c = {1'b0, i_value[WIDTH-1:1]};
      o_target_c  = i_value[0];
    end else begin
      o_shifted_c = {i_value[WIDTH-2:0], 1'b0};
      o_target_c  = i_value[WIDTH-1];
    end
    o_zero_c = (i_value == '0);
  end

endmodule

// File: rtl/normalizer.sv
// Iterative normalizer: shifts one bit per cycle until the target bit is set, reporting the shift count.
module normalizer
  import normalizer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   valueEntry,
  input  logic               direction,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [COUNT_W-1:0] count,
  output logic               zero
);

  state_e             r_state;
  logic [WIDTH-1:0]   r_work;
  logic               r_dir;
  logic [COUNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [COUNT_W-1:0] r_count;
  logic               r_zero;

  logic [WIDTH-1:0]   w_shifted;
  logic               w_target;
  logic               w_zero;

  shift_step u_shift_step (
    .i_value     (r_work),
    .i_dir       (r_dir),
    .o_shifted_c (w_shifted),
    .o_target_c  (w_target),
    .o_zero_c    (w_zero)
  );

  // Control FSM; result/count/zero only change on completion so they hold between operations
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_dir    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_count  <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work  <= valueEntry;
            r_dir   <= direction;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_zero) begin
            r_result <= '0;
            r_count  <= COUNT_W'(ZERO_COUNT);
            r_zero   <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else if (w_target) begin
            r_result <= r_work;
            r_count  <= r_cnt;
            r_zero   <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            // A nonzero operand hits its target within 15 shifts, so r_cnt cannot wrap
            r_work <= w_shifted;
            r_cnt  <= r_cnt + COUNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign count  = r_count;
  assign zero   = r_zero;

endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for normalizer: stimulus queues expected completions, a monitor checks each done pulse.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] valueEntry;
  logic        direction;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [4:0]  count;
  logic        zero;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  cnt;
    logic        zf;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  normalizer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .valueEntry (valueEntry),
    .direction  (direction),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .count      (count),
    .zero       (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation, including its cycle
  always @(negedge clk) begin
    if (reset && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result", int'(result), int'(e.res));
        check("count", int'(count), int'(e.cnt));
        check("zero", int'(zero), int'(e.zf));
        check("latency", cyc, e.cyc);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Called at a negedge; start is sampled on the next edge (E0), done expected after E0+n+1
  task automatic issue(input logic [15:0] v, input logic d, input logic [15:0] er,
                       input logic [4:0] ec, input logic ez, input int n);
    exp_t e;
    start      = 1'b1;
    valueEntry = v;
    direction  = d;
    e.res = er;
    e.cnt = ec;
    e.zf  = ez;
    e.cyc = cyc + n + 2;
    sbq.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    valueEntry = ~v;
    direction  = ~d;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d completions still pending", name, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  function automatic void model(input logic [15:0] v, input logic d,
                                output logic [15:0] r, output logic [4:0] c);
    int pos;
    pos = 0;
    if (v == 16'h0000) begin
      r = 16'h0000;
      c = 5'd16;
      return;
    end
    if (!d) begin
      for (int i = 0; i < 16; i++) if (v[i]) pos = i;
      c = 5'(15 - pos);
      r = v << c;
    end else begin
      for (int i = 15; i >= 0; i--) if (v[i]) pos = i;
      c = 5'(pos);
      r = v >> c;
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rv;
    logic        rd;
    logic [15:0] er;
    logic [4:0]  ec;

    reset      = 1'b0;
    start      = 1'b0;
    valueEntry = 16'h0000;
    direction  = 1'b0;
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_count", int'(count), 0);
    check("rst_zero", int'(zero), 0);
    @(negedge clk);
    reset = 1'b1;

    // First start right after release is accepted with no recovery cycles
    @(negedge clk);
    issue(16'h0001, 1'b0, 16'h8000, 5'd15, 1'b0, 15);
    check("busy_during_op", int'(busy), 1);
    wait_drain("lz_worst");

    // Already normalized, then back-to-back start in the done cycle
    issue(16'h8000, 1'b0, 16'h8000, 5'd0, 1'b0, 0);
    @(negedge clk);
    check("done_pulse", int'(done), 1);
    check("busy_low_in_done", int'(busy), 0);
    issue(16'h0100, 1'b0, 16'h8000, 5'd7, 1'b0, 7);
    wait_drain("back_to_back");

    // Right normalize; start while busy at E0+2 must be ignored
    issue(16'h00F0, 1'b1, 16'h000F, 5'd4, 1'b0, 4);
    @(negedge clk);
    start      = 1'b1;
    valueEntry = 16'hFFFF;
    direction  = 1'b0;
    @(negedge clk);
    check("busy_ignored_start", int'(busy), 1);
    start = 1'b0;
    wait_drain("tz_ignore");

    issue(16'h0000, 1'b0, 16'h0000, 5'd16, 1'b1, 0);
    wait_drain("zero_d0");
    check("zero_holds", int'(zero), 1);
    check("count_holds", int'(count), 16);
    issue(16'h0000, 1'b1, 16'h0000, 5'd16, 1'b1, 0);
    wait_drain("zero_d1");
    issue(16'h4000, 1'b1, 16'h0001, 5'd14, 1'b0, 14);
    wait_drain("tz_14");
    issue(16'h0003, 1'b0, 16'hC000, 5'd14, 1'b0, 14);
    wait_drain("lz_14");
    check("result_holds", int'(result), 16'hC000);

    // Reset mid-operation: outputs clear immediately and no done follows
    start      = 1'b1;
    valueEntry = 16'h0001;
    direction  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_rst", int'(busy), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_zero", int'(zero), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("idle_after_rst", int'(busy), 0);

    for (int i = 0; i < 1000; i++) begin
      rv = 16'($urandom) >> $urandom_range(0, 15);
      if (i % 97 == 0) rv = 16'h0000;
      rd = 1'($urandom_range(0, 1));
      model(rv, rd, er, ec);
      issue(rv, rd, er, ec, (rv == 16'h0000), (rv == 16'h0000) ? 0 : int'(ec));
      wait_drain("random");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/normalizer.md
NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 Parameters SHALL be none; widths are fixed: WIDTH=16 for the value path, COUNT_W=5 for the shift count.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; the port keeps the name reset, but asserted = 0.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 valueEntry  input  16  operand; captured on the accepted start edge.
REQ-006 direction  input  1  captured with start; 0 = normalize toward bit 15 (left shifts, count leading zeros), 1 = normalize toward bit 0 (right shifts, count trailing zeros).
REQ-007 busy  output  1  high while an operation is in progress (state SHIFT).
REQ-008 done  output  1  registered one-cycle completion pulse.
REQ-009 result  output  16  normalized value; holds until the next completion.
REQ-010 count  output  5  number of single-bit shifts applied, 0..15, or 16 for zero input; holds like result.
REQ-011 zero  output  1  high when the last completed operand was 0x0000; holds like result.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and SHIFT; reset enters IDLE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL capture valueEntry into a working register, capture direction, clear the internal counter, and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL evaluate the working register:
- working == 0: finish with result=0, count=16, zero=1.
- target bit set (bit 15 if direction=0, bit 0 if direction=1): finish with result=working, count=counter, zero=0.
- otherwise: shift working one bit toward the target end, zero-filling the vacated bit, and increment counter.
REQ-015 Finishing SHALL load result/count/zero, assert done for exactly the following cycle, and return to IDLE on that same edge.
REQ-016 Latency SHALL be deterministic: done is high in the cycle after edge E0+N+1 for an N-shift operand, and after E0+1 for a zero operand; worst case is E0+16.
REQ-017 busy SHALL be high exactly while in SHIFT, and SHALL fall on the same edge where done rises.
REQ-018 start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-019 start in the cycle where done=1 SHALL be accepted, because the state is IDLE then.
REQ-020 Changes to valueEntry or direction after E0 SHALL not affect the operation in progress.
REQ-021 The counter SHALL never exceed 15 for a nonzero operand; no wrap-around is possible.

Reset
REQ-022 reset=0 SHALL immediately force IDLE, busy=0, done=0, result=0x0000, count=0, zero=0, and clear the working register and counter, including mid-operation.
REQ-023 After deassertion, the first start SHALL be accepted on the next rising edge, with no other recovery cycles.

Structure
REQ-024 A shared package normalizer_pkg SHALL hold WIDTH=16, COUNT_W=5, ZERO_COUNT=16, and the state encoding (IDLE=0, SHIFT=1).
REQ-025 One combinational sub-module, shift_step, SHALL compute the single-bit directional shift and target-bit test.
REQ-026 All other logic SHALL reside in normalizer.

Verification
REQ-027 valueEntry=0x0001, direction=0, start at E0 -> done after E0+16, result=0x8000, count=15, zero=0.
REQ-028 valueEntry=0x8000, direction=0 -> done after E0+1, result=0x8000, count=0; back-to-back start during the done cycle with 0x0100 is accepted -> result=0x8000, count=7.
REQ-029 valueEntry=0x00F0, direction=1 -> result=0x000F, count=4, done after E0+5; a second start at E0+2 with 0xFFFF is ignored.
REQ-030 valueEntry=0x0000 (either direction) -> done after E0+1, result=0x0000, count=16, zero=1.
REQ-031 valueEntry=0x0001, direction=0, reset=0 asserted at E0+5 -> busy=0, done=0, all outputs 0 immediately; no done follows after release.
REQ-032 Random operands, 1000 iterations -> count equals the leading-zero (dir 0) or trailing-zero (dir 1) count, and result equals valueEntry shifted by count.
